// File: rtl/serial_link_pkg.sv
// Shared definitions for the 2-bit serial link (transmit and receive sides).
// Holds the comma byte, lane widths and the link state encoding.
package serial_link_pkg;

    localparam int         PAIR_W      = 2;
    localparam int         BYTE_W      = 8;
    localparam int         WORD_W      = 9;
    localparam logic [7:0] BC_WORD_DEF = 8'hBC;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } link_state_e;

endpackage

// File: rtl/serial_paralelo_2b_if.sv
// Receive-side bundle of the 2-bit link deserializer: serial pair in, parallel word and status out.
// Handshake: no backpressure; a word is valid in the cycle word_strobe is high, and is then held.
interface serial_paralelo_2b_if;
    import serial_link_pkg::*;

    logic [PAIR_W-1:0] serial_in;
    logic [WORD_W-1:0] paralelo_out;
    logic              word_strobe;
    logic              active;
    logic              aligned;
    link_state_e       state_dbg;

    modport master (
        output serial_in,
        input  paralelo_out, word_strobe, active, aligned, state_dbg
    );

    modport slave (
        input  serial_in,
        output paralelo_out, word_strobe, active, aligned, state_dbg
    );

endinterface

// File: rtl/sp_word_assembler.sv
// Shift register and 2-bit word phase for the deserializer.
// cand is the byte that completes on this edge; boundary marks the fourth pair of an aligned word.
module sp_word_assembler
    import serial_link_pkg::*;
(
    input  logic              clk16f,
    input  logic              reset,
    input  logic [PAIR_W-1:0] serial_in,
    input  logic              phase_load,
    output logic [BYTE_W-1:0] cand,
    output logic              boundary
);

    logic [BYTE_W-1:0] sr_q, sr_d;
    logic [1:0]        phase_q, phase_d;

    always_comb begin
        sr_d    = {sr_q[BYTE_W-PAIR_W-1:0], serial_in};
        phase_d = phase_load ? 2'd0 : phase_q + 2'd1;
    end

    assign cand     = sr_d;
    assign boundary = (phase_q == 2'd3);

    always_ff @(posedge clk16f) begin
        if (reset) begin
            sr_q    <= '0;
            phase_q <= 2'd0;
        end else begin
            sr_q    <= sr_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/serial_paralelo_2b.sv
// 2-bit serial to 9-bit parallel deserializer: finds the comma, locks after LOCK_COUNT
// aligned commas, then emits one {valid, byte} word per four serial clocks.
module serial_paralelo_2b
    import serial_link_pkg::*;
#(
    parameter logic [7:0] BC_WORD    = BC_WORD_DEF,
    parameter int         LOCK_COUNT = 4
) (
    input  logic                 clk16f,
    input  logic                 reset,
    serial_paralelo_2b_if.slave  bus
);

    localparam int             CNT_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] LOCK_V = CNT_W'(LOCK_COUNT);

    logic [BYTE_W-1:0] cand;
    logic              boundary;
    logic              phase_load;

    link_state_e       state_q, state_d;
    logic [CNT_W-1:0]  bc_cnt_q, bc_cnt_d;
    logic [WORD_W-1:0] paralelo_q, paralelo_d;
    logic              strobe_q, strobe_d;
    logic              active_q, active_d;
    logic              aligned_q, aligned_d;

    sp_word_assembler u_asm (
        .clk16f     (clk16f),
        .reset      (reset),
        .serial_in  (bus.serial_in),
        .phase_load (phase_load),
        .cand       (cand),
        .boundary   (boundary)
    );

    always_comb begin
        state_d    = state_q;
        bc_cnt_d   = bc_cnt_q;
        paralelo_d = paralelo_q;
        strobe_d   = 1'b0;
        phase_load = 1'b0;
        case (state_q)
            SEARCH: begin
                // Comma at any pair offset fixes the word phase: next pair is pair 0.
                if (cand == BC_WORD) begin
                    phase_load = 1'b1;
                    bc_cnt_d   = CNT_W'(1);
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (cand == BC_WORD) begin
                        if (bc_cnt_q + CNT_W'(1) == LOCK_V) state_d = ACTIVE;
                        if (bc_cnt_q != LOCK_V) bc_cnt_d = bc_cnt_q + CNT_W'(1);
                    end else begin
                        state_d  = SEARCH;
                        bc_cnt_d = '0;
                    end
                end
            end
            ACTIVE: begin
                if (boundary) begin
                    paralelo_d = (cand == BC_WORD) ? {1'b0, BC_WORD} : {1'b1, cand};
                    strobe_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
        active_d  = (state_d == ACTIVE);
        aligned_d = (state_d != SEARCH);
    end

    always_ff @(posedge clk16f) begin
        if (reset) begin
            state_q    <= SEARCH;
            bc_cnt_q   <= '0;
            paralelo_q <= '0;
            strobe_q   <= 1'b0;
            active_q   <= 1'b0;
            aligned_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bc_cnt_q   <= bc_cnt_d;
            paralelo_q <= paralelo_d;
            strobe_q   <= strobe_d;
            active_q   <= active_d;
            aligned_q  <= aligned_d;
        end
    end

    assign bus.paralelo_out = paralelo_q;
    assign bus.word_strobe  = strobe_q;
    assign bus.active       = active_q;
    assign bus.aligned      = aligned_q;
    assign bus.state_dbg    = state_q;

endmodule
